// File: rtl/stopwatch_controller_if.sv
// Stopwatch controller signal bundle: divider/switch/button inputs and MM:SS display outputs.
// master drives the inputs (test/board side); slave is the controller.
interface stopwatch_controller_if;
  logic       clk_1hz;
  logic       clk_2hz;
  logic       clk_blink;
  logic       sw_adj;
  logic       sw_sel;
  logic       btn_pause;
  logic       btn_reset;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blank_min;
  logic       blank_sec;
  logic       running;
  logic [1:0] state;

  modport master (
    output clk_1hz, clk_2hz, clk_blink, sw_adj, sw_sel, btn_pause, btn_reset,
    input  minutes, seconds, blank_min, blank_sec, running, state
  );

  modport slave (
    input  clk_1hz, clk_2hz, clk_blink, sw_adj, sw_sel, btn_pause, btn_reset,
    output minutes, seconds, blank_min, blank_sec, running, state
  );
endinterface

// File: rtl/stopwatch_controller.sv
// IDLE/RUN/PAUSE/ADJ stopwatch FSM with MM:SS count; divider outputs are synchronised data, ticks land
// SYNC_STAGES+1 clk_in edges after a divider rise; all outputs registered, no backpressure.
module stopwatch_controller #(
  parameter int MAX_MIN     = 59,
  parameter int MAX_SEC     = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  stopwatch_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ADJ   = 2'd3
  } state_t;

  localparam int         LAST    = SYNC_STAGES - 1;
  localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);
  localparam logic [5:0] SEC_TOP = 6'(MAX_SEC);

  logic [LAST:0] sync_1hz, sync_2hz, sync_blink, sync_adj, sync_sel;
  logic          d_1hz, d_2hz;
  logic          tick_1hz, tick_2hz, adj_s, sel_s, blink_s;

  state_t     state_q;
  logic [5:0] min_q, sec_q;
  logic       blank_min_q, blank_sec_q, running_q;

  assign adj_s    = sync_adj[LAST];
  assign sel_s    = sync_sel[LAST];
  assign blink_s  = sync_blink[LAST];
  assign tick_1hz = sync_1hz[LAST] & ~d_1hz;
  assign tick_2hz = sync_2hz[LAST] & ~d_2hz;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_1hz    <= '0;
      sync_2hz    <= '0;
      sync_blink  <= '0;
      sync_adj    <= '0;
      sync_sel    <= '0;
      d_1hz       <= 1'b0;
      d_2hz       <= 1'b0;
      state_q     <= IDLE;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      sync_1hz   <= {sync_1hz[LAST-1:0], bus.clk_1hz};
      sync_2hz   <= {sync_2hz[LAST-1:0], bus.clk_2hz};
      sync_blink <= {sync_blink[LAST-1:0], bus.clk_blink};
      sync_adj   <= {sync_adj[LAST-1:0], bus.sw_adj};
      sync_sel   <= {sync_sel[LAST-1:0], bus.sw_sel};
      d_1hz      <= sync_1hz[LAST];
      d_2hz      <= sync_2hz[LAST];

      // Next state is ADJ exactly when adj_s is high, so blanking tracks the registered state.
      blank_min_q <= adj_s & sel_s & blink_s;
      blank_sec_q <= adj_s & ~sel_s & blink_s;

      if (adj_s) begin
        running_q <= 1'b0;
        if (state_q != ADJ) begin
          state_q <= ADJ;
        end else if (bus.btn_reset) begin
          min_q <= 6'd0;
          sec_q <= 6'd0;
        end else if (tick_2hz) begin
          if (sel_s) min_q <= (min_q == MIN_TOP) ? 6'd0 : min_q + 6'd1;
          else       sec_q <= (sec_q == SEC_TOP) ? 6'd0 : sec_q + 6'd1;
        end
      end else if (state_q == ADJ) begin
        state_q   <= PAUSE;
        running_q <= 1'b0;
      end else if (bus.btn_reset) begin
        min_q     <= 6'd0;
        sec_q     <= 6'd0;
        state_q   <= IDLE;
        running_q <= 1'b0;
      end else begin
        if (state_q == RUN && tick_1hz) begin
          if (sec_q == SEC_TOP) begin
            sec_q <= 6'd0;
            min_q <= (min_q == MIN_TOP) ? 6'd0 : min_q + 6'd1;
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end
        if (bus.btn_pause) begin
          if (state_q == RUN) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.minutes   = min_q;
  assign bus.seconds   = sec_q;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_sec = blank_sec_q;
  assign bus.running   = running_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed scenarios plus a random soak, every cycle compared
// against a time-count reference model fed by delayed input samples.
module tb_stopwatch_controller;
  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  stopwatch_controller_if bus();

  stopwatch_controller #(.MAX_MIN(59), .MAX_SEC(59), .SYNC_STAGES(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: count as minutes/seconds, state as 0..3; h*[k] = input sampled k+1 edges ago.
  int       m_state, m_min, m_sec;
  bit       m_bmin, m_bsec;
  bit [2:0] h1, h2, hb, ha, hs;

  function automatic void model_reset();
    m_state = 0; m_min = 0; m_sec = 0; m_bmin = 0; m_bsec = 0;
    h1 = '0; h2 = '0; hb = '0; ha = '0; hs = '0;
  endfunction

  function automatic void model_edge();
    bit t1, t2, adj, sel, blk;
    int tot;
    t1  = h1[1] & ~h1[2];
    t2  = h2[1] & ~h2[2];
    adj = ha[1];
    sel = hs[1];
    blk = hb[1];
    m_bmin = adj & sel & blk;
    m_bsec = adj & ~sel & blk;
    if (adj) begin
      if (m_state != 3) m_state = 3;
      else if (bus.btn_reset) begin m_min = 0; m_sec = 0; end
      else if (t2) begin
        if (sel) m_min = (m_min + 1) % 60;
        else     m_sec = (m_sec + 1) % 60;
      end
    end else if (m_state == 3) begin
      m_state = 2;
    end else if (bus.btn_reset) begin
      m_min = 0; m_sec = 0; m_state = 0;
    end else begin
      if (m_state == 1 && t1) begin
        tot   = (m_min * 60 + m_sec + 1) % 3600;
        m_min = tot / 60;
        m_sec = tot % 60;
      end
      if (bus.btn_pause) m_state = (m_state == 1) ? 2 : 1;
    end
    h1 = {h1[1:0], bus.clk_1hz};
    h2 = {h2[1:0], bus.clk_2hz};
    hb = {hb[1:0], bus.clk_blink};
    ha = {ha[1:0], bus.sw_adj};
    hs = {hs[1:0], bus.sw_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("minutes", 32'(bus.minutes), 32'(m_min));
    chk("seconds", 32'(bus.seconds), 32'(m_sec));
    chk("state", 32'(bus.state), 32'(m_state));
    chk("running", 32'(bus.running), 32'(m_state == 1));
    chk("blank_min", 32'(bus.blank_min), 32'(m_bmin));
    chk("blank_sec", 32'(bus.blank_sec), 32'(m_bsec));
  endtask

  task automatic cycle();
    if ($urandom_range(0, 3) == 0) bus.clk_blink = ~bus.clk_blink;
    @(posedge clk_in);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  task automatic edge_1hz();
    bus.clk_1hz = 1'b1; repeat (3) cycle();
    bus.clk_1hz = 1'b0; repeat (3) cycle();
  endtask

  task automatic edge_2hz(input bit with_1hz);
    bus.clk_2hz = 1'b1; bus.clk_1hz = with_1hz; repeat (3) cycle();
    bus.clk_2hz = 1'b0; bus.clk_1hz = 1'b0;     repeat (3) cycle();
  endtask

  task automatic press_pause();
    bus.btn_pause = 1'b1; cycle(); bus.btn_pause = 1'b0;
  endtask

  task automatic press_reset();
    bus.btn_reset = 1'b1; cycle(); bus.btn_reset = 1'b0;
  endtask

  task automatic set_adj(input bit v);
    bus.sw_adj = v; repeat (3) cycle();
  endtask

  task automatic set_sel(input bit v);
    bus.sw_sel = v; repeat (3) cycle();
  endtask

  task automatic expect_mmss(input string tag, input int mm, input int ss, input int st);
    chk({tag, "_min"}, 32'(bus.minutes), 32'(mm));
    chk({tag, "_sec"}, 32'(bus.seconds), 32'(ss));
    chk({tag, "_state"}, 32'(bus.state), 32'(st));
  endtask

  // Preload mm:ss through ADJ starting from any state; leaves the bench in ADJ with sel=0.
  task automatic preload(input int mm, input int ss);
    set_adj(1'b1);
    press_reset();
    set_sel(1'b1);
    repeat (mm) edge_2hz(1'b0);
    set_sel(1'b0);
    repeat (ss) edge_2hz(1'b0);
  endtask

  initial begin
    int c1, c2;
    rst = 1'b1;
    bus.clk_1hz = 0; bus.clk_2hz = 0; bus.clk_blink = 0;
    bus.sw_adj = 0; bus.sw_sel = 0; bus.btn_pause = 0; bus.btn_reset = 0;
    model_reset();
    #22;
    check_all();
    expect_mmss("reset", 0, 0, 0);
    rst = 1'b0;
    repeat (2) cycle();

    // Start and count three seconds, with an explicit latency probe on the first one.
    press_pause();
    bus.clk_1hz = 1'b1;
    repeat (2) cycle();
    chk("lat_before", 32'(bus.seconds), 32'd0);
    cycle();
    chk("lat_at", 32'(bus.seconds), 32'd1);
    bus.clk_1hz = 1'b0; repeat (3) cycle();
    repeat (2) edge_1hz();
    expect_mmss("run3", 0, 3, 1);

    // Seconds carry into minutes, then full wrap.
    preload(0, 58);
    expect_mmss("pre58", 0, 58, 3);
    set_adj(1'b0);
    press_pause();
    edge_1hz();
    expect_mmss("to59", 0, 59, 1);
    edge_1hz();
    expect_mmss("carry", 1, 0, 1);
    preload(59, 59);
    expect_mmss("pre5959", 59, 59, 3);
    set_adj(1'b0);
    press_pause();
    edge_1hz();
    expect_mmss("wrap", 0, 0, 1);
    chk("wrap_running", 32'(bus.running), 32'd1);

    // Pause coincident with a tick: count advances and state pauses.
    repeat (5) edge_1hz();
    expect_mmss("at5", 0, 5, 1);
    bus.clk_1hz = 1'b1;
    repeat (2) cycle();
    press_pause();
    bus.clk_1hz = 1'b0; repeat (3) cycle();
    expect_mmss("pause_tick", 0, 6, 2);
    repeat (4) edge_1hz();
    expect_mmss("frozen", 0, 6, 2);
    press_pause();
    chk("resume_state", 32'(bus.state), 32'd1);

    // Seconds adjust wraps without carry; 1 Hz edges ignored in ADJ.
    set_adj(1'b1);
    press_reset();
    repeat (62) edge_2hz(1'b1);
    expect_mmss("adj62", 0, 2, 3);
    chk("adj_blank_min", 32'(bus.blank_min), 32'd0);

    // Reset inside ADJ keeps ADJ; leaving ADJ pauses; reset then idles.
    preload(5, 10);
    expect_mmss("pre510", 5, 10, 3);
    press_reset();
    expect_mmss("adj_reset", 0, 0, 3);
    set_adj(1'b0);
    expect_mmss("adj_exit", 0, 0, 2);
    press_reset();
    expect_mmss("idle_reset", 0, 0, 0);

    // Async reset mid-run with 1 Hz high; spurious tick afterwards lands in IDLE.
    preload(12, 34);
    set_adj(1'b0);
    press_pause();
    expect_mmss("pre1234", 12, 34, 1);
    bus.clk_1hz = 1'b1;
    cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    expect_mmss("rst_mid", 0, 0, 0);
    chk("rst_blank", 32'({bus.blank_min, bus.blank_sec}), 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (6) cycle();
    expect_mmss("post_rst", 0, 0, 0);
    bus.clk_1hz = 1'b0;

    // Random soak against the model.
    c1 = 3; c2 = 2;
    for (int i = 0; i < 3000; i++) begin
      c1--; c2--;
      if (c1 <= 0) begin bus.clk_1hz = ~bus.clk_1hz; c1 = $urandom_range(1, 7); end
      if (c2 <= 0) begin bus.clk_2hz = ~bus.clk_2hz; c2 = $urandom_range(1, 5); end
      bus.btn_pause = ($urandom_range(0, 24) == 0);
      bus.btn_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) bus.sw_adj = ~bus.sw_adj;
      if ($urandom_range(0, 39) == 0)  bus.sw_sel = ~bus.sw_sel;
      cycle();
    end
    bus.btn_pause = 1'b0;
    bus.btn_reset = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
